// File: rtl/dcache_store_port.sv
// rtl/dcache_store_port.sv - direct-mapped write-back data cache: store buffer port, load port, miss FSM
`timescale 1ns/1ps
module dcache_store_port #(
  parameter int WORD_SIZE        = 32,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int SIZE_WRITE_WIDTH = 2,
  parameter int LINE_SIZE        = 128,
  parameter int NUM_LINES        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_req,
  input  logic [ADDRESS_WIDTH-1:0]    load_addr,
  output logic                        load_valid,
  output logic [WORD_SIZE-1:0]        load_data,
  input  logic                        cache_wenable,
  input  logic [ADDRESS_WIDTH-1:0]    cache_physical_address,
  input  logic [WORD_SIZE-1:0]        cache_store_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
  output logic                        store_success,
  output logic                        busy,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDRESS_WIDTH-1:0]    mem_addr,
  output logic [LINE_SIZE-1:0]        mem_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [LINE_SIZE-1:0]        mem_rdata
);

  localparam int OFF   = $clog2(LINE_SIZE / 8);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG   = ADDRESS_WIDTH - IDX - OFF;
  localparam int BYTES = LINE_SIZE / 8;
  localparam int WORDS = LINE_SIZE / WORD_SIZE;
  localparam int WB    = $clog2(WORD_SIZE / 8);
  localparam int WSEL  = OFF - WB;
  localparam logic [BYTES-1:0] WORD_MASK = BYTES'((1 << (WORD_SIZE / 8)) - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} state_t;

  state_t                 state;
  logic [LINE_SIZE-1:0]   data_arr [NUM_LINES];
  logic [TAG-1:0]         tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;
  logic [TAG-1:0]         miss_tag;
  logic [IDX-1:0]         miss_idx;

  logic                     take_load, take_store, access, hit, miss;
  logic                     store_we, fill_we;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [TAG-1:0]           acc_tag;
  logic [IDX-1:0]           acc_idx;
  logic [OFF-1:0]           byte_pos;
  logic [LINE_SIZE-1:0]     cur_line, st_data, merged;
  logic [BYTES-1:0]         st_mask;
  logic [WORD_SIZE-1:0]     rd_word;

  // A request still held during its own ack pulse must not be taken a second time.
  assign take_load  = (state == IDLE) && load_req && !load_valid;
  assign take_store = (state == IDLE) && !take_load && cache_wenable && !store_success;
  assign access     = take_load || take_store;
  assign acc_addr   = take_load ? load_addr : cache_physical_address;
  assign acc_tag    = acc_addr[ADDRESS_WIDTH-1:IDX+OFF];
  assign acc_idx    = acc_addr[IDX+OFF-1:OFF];
  assign byte_pos   = acc_addr[OFF-1:0];
  assign cur_line   = data_arr[acc_idx];
  assign hit        = valid_q[acc_idx] && (tag_arr[acc_idx] == acc_tag);
  assign miss       = access && !hit;
  assign store_we   = take_store && hit;
  assign fill_we    = (state == FILL_WAIT) && mem_rsp_valid;
  assign busy       = !reset && ((state != IDLE) || miss);

  always_comb begin
    st_mask = '0;
    st_data = '0;
    case (cache_store_size)
      SIZE_WRITE_WIDTH'(0): begin
        st_mask = BYTES'(1) << byte_pos;
        st_data = {BYTES{cache_store_value[7:0]}};
      end
      SIZE_WRITE_WIDTH'(1): begin
        st_mask = BYTES'(3) << {byte_pos[OFF-1:1], 1'b0};
        st_data = {(BYTES/2){cache_store_value[15:0]}};
      end
      default: begin
        st_mask = WORD_MASK << {byte_pos[OFF-1:WB], {WB{1'b0}}};
        st_data = {WORDS{cache_store_value}};
      end
    endcase
  end

  always_comb begin
    merged = cur_line;
    for (int b = 0; b < BYTES; b++) begin
      if (st_mask[b]) merged[b*8 +: 8] = st_data[b*8 +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (acc_addr[OFF-1:WB] == WSEL'(w)) rd_word = cur_line[w*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Line storage carries no reset; valid bits alone decide what is resident.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[miss_idx] <= mem_rdata;
      tag_arr[miss_idx]  <= miss_tag;
    end else if (store_we) begin
      data_arr[acc_idx] <= merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      miss_tag      <= '0;
      miss_idx      <= '0;
      load_valid    <= 1'b0;
      load_data     <= '0;
      store_success <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      load_valid    <= 1'b0;
      store_success <= 1'b0;
      mem_req       <= 1'b0;
      case (state)
        IDLE: begin
          if (access && hit) begin
            if (take_load) begin
              load_valid <= 1'b1;
              load_data  <= rd_word;
            end else begin
              store_success    <= 1'b1;
              dirty_q[acc_idx] <= 1'b1;
            end
          end else if (miss) begin
            miss_tag <= acc_tag;
            miss_idx <= acc_idx;
            mem_req  <= 1'b1;
            if (valid_q[acc_idx] && dirty_q[acc_idx]) begin
              state     <= WB_REQ;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_arr[acc_idx], acc_idx, {OFF{1'b0}}};
              mem_wdata <= cur_line;
            end else begin
              state    <= FILL_REQ;
              mem_we   <= 1'b0;
              mem_addr <= {acc_tag, acc_idx, {OFF{1'b0}}};
            end
          end
        end
        WB_REQ: state <= WB_WAIT;
        WB_WAIT: begin
          if (mem_rsp_valid) begin
            dirty_q[miss_idx] <= 1'b0;
            state             <= FILL_REQ;
            mem_req           <= 1'b1;
            mem_we            <= 1'b0;
            mem_addr          <= {miss_tag, miss_idx, {OFF{1'b0}}};
          end
        end
        FILL_REQ: state <= FILL_WAIT;
        FILL_WAIT: begin
          if (mem_rsp_valid) begin
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
